seven_seg_capture: RTL and testbench

//   Receive-side counterpart of the common-anode 7-segment driver on the Elbert Spartan 3A board.

---
 rtl/seven_seg_capture.sv | 147 ++++++++++++++
 tb/tb_seven_seg_capture.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// Receive-side capture of a multiplexed common-anode 7-segment display.
// Samples the digit-enable, segment and dot lines, waits for a stable pattern, and decodes it back to a hex nibble per digit.
module seven_seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_e0,
  input  logic        i_e1,
  input  logic        i_e2,
  input  logic        i_a,
  input  logic        i_b,
  input  logic        i_c,
  input  logic        i_d,
  input  logic        i_e,
  input  logic        i_f,
  input  logic        i_g,
  input  logic        i_dot,
  input  logic        i_clr_err,
  output logic [11:0] o_value,
  output logic [2:0]  o_digit_valid,
  output logic [2:0]  o_dot_seen,
  output logic        o_update,
  output logic        o_pattern_err
);

  localparam logic [7:0] L_STABLE = 8'(STABLE_CYCLES);

  // Returns {legal, nibble}; segment order is a..g with a in the MSB, active-high.
  function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h7E:   res = {1'b1, 4'h0};
      7'h30:   res = {1'b1, 4'h1};
      7'h6D:   res = {1'b1, 4'h2};
      7'h79:   res = {1'b1, 4'h3};
      7'h33:   res = {1'b1, 4'h4};
      7'h5B:   res = {1'b1, 4'h5};
      7'h5F:   res = {1'b1, 4'h6};
      7'h70:   res = {1'b1, 4'h7};
      7'h7F:   res = {1'b1, 4'h8};
      7'h7B:   res = {1'b1, 4'h9};
      7'h77:   res = {1'b1, 4'hA};
      7'h1F:   res = {1'b1, 4'hB};
      7'h4E:   res = {1'b1, 4'hC};
      7'h3D:   res = {1'b1, 4'hD};
      7'h4F:   res = {1'b1, 4'hE};
      7'h47:   res = {1'b1, 4'hF};
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

  // Raw (active-low) sample {e2,e1,e0,a..g,dot}; all ones means nothing selected.
  logic [10:0] r_raw;
  logic [10:0] r_prev;
  logic [7:0]  r_cnt;

  logic [2:0]  w_en;
  logic [6:0]  w_seg;
  logic        w_dp;
  logic        w_one_hot;
  logic        w_multi;
  logic        w_same;
  logic [1:0]  w_idx;
  logic [4:0]  w_glyph;
  logic        w_blank;
  logic [7:0]  w_cnt_next;
  logic        w_decode;
  logic        w_err_new;

  assign w_en      = ~r_raw[10:8];
  assign w_seg     = ~r_raw[7:1];
  assign w_dp      = ~r_raw[0];
  assign w_one_hot = (w_en == 3'b001) || (w_en == 3'b010) || (w_en == 3'b100);
  assign w_multi   = (w_en[0] & w_en[1]) | (w_en[0] & w_en[2]) | (w_en[1] & w_en[2]);
  assign w_same    = (r_raw == r_prev);
  assign w_glyph   = glyph_decode(w_seg);
  assign w_blank   = (w_seg == 7'h00);
  assign w_err_new = w_multi | (w_decode & ~w_blank & ~w_glyph[4]);

  // Selected digit index from the one-hot enable vector.
  always_comb begin
    case (w_en)
      3'b001:  w_idx = 2'd0;
      3'b010:  w_idx = 2'd1;
      3'b100:  w_idx = 2'd2;
      default: w_idx = 2'd0;
    endcase
  end

  // Stability count saturates at the threshold so a held pattern decodes only once.
  always_comb begin
    w_cnt_next = 8'd0;
    w_decode   = 1'b0;
    if (!w_one_hot) begin
      w_cnt_next = 8'd0;
    end else if (!w_same) begin
      w_cnt_next = 8'd1;
    end else if (r_cnt < L_STABLE) begin
      w_cnt_next = r_cnt + 8'd1;
    end else begin
      w_cnt_next = L_STABLE;
    end
    if (w_one_hot && (w_cnt_next == L_STABLE) && (!w_same || (r_cnt != L_STABLE))) begin
      w_decode = 1'b1;
    end else begin
      w_decode = 1'b0;
    end
  end

  // Input sampling, stability tracking and registered decode outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_raw         <= 11'h7FF;
      r_prev        <= 11'h7FF;
      r_cnt         <= 8'd0;
      o_value       <= 12'h000;
      o_digit_valid <= 3'b000;
      o_dot_seen    <= 3'b000;
      o_update      <= 1'b0;
      o_pattern_err <= 1'b0;
    end else begin
      r_raw    <= {i_e2, i_e1, i_e0, i_a, i_b, i_c, i_d, i_e, i_f, i_g, i_dot};
      r_prev   <= r_raw;
      r_cnt    <= w_cnt_next;
      o_update <= w_decode;
      for (int i = 0; i < 3; i++) begin
        if (w_decode && (w_idx == 2'(i))) begin
          if (w_glyph[4]) begin
            o_value[4*i +: 4] <= w_glyph[3:0];
            o_digit_valid[i]  <= 1'b1;
            o_dot_seen[i]     <= w_dp;
          end else begin
            o_digit_valid[i]  <= 1'b0;
          end
        end
      end
      if (w_err_new) begin
        o_pattern_err <= 1'b1;
      end else if (i_clr_err) begin
        o_pattern_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: a behavioural model pushes expected decodes to a scoreboard
// queue while driving, and a monitor pops and compares on every update pulse.
module tb_seven_seg_capture;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        e0 = 1'b1, e1 = 1'b1, e2 = 1'b1;
  logic        a = 1'b1, b = 1'b1, c = 1'b1, d = 1'b1, e = 1'b1, f = 1'b1, g = 1'b1;
  logic        dot = 1'b1;
  logic        clr_err = 1'b0;
  logic [11:0] value;
  logic [2:0]  digit_valid;
  logic [2:0]  dot_seen;
  logic        update;
  logic        pattern_err;

  always #5 clk = ~clk;

  seven_seg_capture #(.STABLE_CYCLES(S)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_e0(e0), .i_e1(e1), .i_e2(e2),
    .i_a(a), .i_b(b), .i_c(c), .i_d(d), .i_e(e), .i_f(f), .i_g(g),
    .i_dot(dot), .i_clr_err(clr_err),
    .o_value(value), .o_digit_valid(digit_valid), .o_dot_seen(dot_seen),
    .o_update(update), .o_pattern_err(pattern_err)
  );

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  logic [17:0] sb[$];
  logic [11:0] m_value = 12'h000;
  logic [2:0]  m_valid = 3'b000;
  logic [2:0]  m_dot = 3'b000;
  logic        m_err = 1'b0;
  logic [10:0] last_key = 11'h7FF;
  int          run = 0;
  logic [6:0]  glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  task automatic drive(input logic ne0, input logic ne1, input logic ne2,
                       input logic [6:0] seg, input logic lit);
    e0 = ne0; e1 = ne1; e2 = ne2;
    {a, b, c, d, e, f, g} = ~seg;
    dot = ~lit;
  endtask

  task automatic model_decode(input int i, input logic [6:0] seg, input logic lit);
    int h;
    h = -1;
    for (int k = 0; k < 16; k++) if (glyph[k] == seg) h = k;
    if (seg == 7'h00) begin
      m_valid[i] = 1'b0;
    end else if (h >= 0) begin
      m_value[4*i +: 4] = 4'(h);
      m_valid[i] = 1'b1;
      m_dot[i] = lit;
    end else begin
      m_valid[i] = 1'b0;
      m_err = 1'b1;
    end
    sb.push_back({m_value, m_valid, m_dot});
  endtask

  // Holds a pattern for n rising edges; the model predicts a decode once the run reaches S.
  task automatic hold(input logic ne0, input logic ne1, input logic ne2,
                      input logic [6:0] seg, input logic lit, input int n);
    logic [10:0] key;
    int nlow;
    int idx;
    key = {ne2, ne1, ne0, ~seg, ~lit};
    if (key == last_key) run += n; else run = n;
    last_key = key;
    nlow = 3 - (int'(ne0) + int'(ne1) + int'(ne2));
    idx = (!ne0) ? 0 : ((!ne1) ? 1 : 2);
    if (nlow == 1 && run >= S && (run - n) < S) model_decode(idx, seg, lit);
    if (nlow > 1) m_err = 1'b1;
    drive(ne0, ne1, ne2, seg, lit);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    hold(1'b1, 1'b1, 1'b1, 7'h00, 1'b0, S + 3);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL drain: pending expected updates %0d, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 7'h00, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if ({value, digit_valid, dot_seen, update, pattern_err} !== 20'h0) begin
      errors++;
      $display("FAIL reset: got %h,%b,%b,%b,%b required all zero",
               value, digit_valid, dot_seen, update, pattern_err);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (update !== 1'b0 || upd_cnt !== 0) begin
      errors++;
      $display("FAIL reset_idle: update %b count %0d, required 0", update, upd_cnt);
    end
  endtask

  task automatic test_digit2_zero();
    upd_cnt = 0;
    hold(1'b1, 1'b1, 1'b0, 7'h7E, 1'b0, S);
    drain();
    checks++;
    if (upd_cnt !== 1 || value[11:8] !== 4'h0 || digit_valid !== 3'b100) begin
      errors++;
      $display("FAIL digit2_zero: updates %0d nib %h valid %b, required 1 0 100",
               upd_cnt, value[11:8], digit_valid);
    end
  endtask

  task automatic test_long_hold_dot();
    upd_cnt = 0;
    hold(1'b1, 1'b0, 1'b1, 7'h4F, 1'b1, 20);
    drain();
    checks++;
    if (upd_cnt !== 1 || value[7:4] !== 4'hE || digit_valid[1] !== 1'b1 || dot_seen[1] !== 1'b1) begin
      errors++;
      $display("FAIL long_hold: updates %0d nib %h valid %b dot %b, required 1 E 1 1",
               upd_cnt, value[7:4], digit_valid[1], dot_seen[1]);
    end
  endtask

  task automatic test_glitch();
    upd_cnt = 0;
    hold(1'b0, 1'b1, 1'b1, 7'h30, 1'b0, S - 1);
    hold(1'b0, 1'b1, 1'b1, 7'h6D, 1'b0, S);
    drain();
    checks++;
    if (upd_cnt !== 1 || value[3:0] !== 4'h2 || value !== m_value) begin
      errors++;
      $display("FAIL glitch: updates %0d value %h, required 1 %h", upd_cnt, value, m_value);
    end
  endtask

  task automatic test_illegal_glyph();
    upd_cnt = 0;
    hold(1'b1, 1'b1, 1'b0, 7'h01, 1'b0, S);
    drain();
    checks++;
    if (pattern_err !== 1'b1 || digit_valid[2] !== 1'b0 || value[11:8] !== 4'h0 || upd_cnt !== 1) begin
      errors++;
      $display("FAIL illegal: err %b valid2 %b nib %h updates %0d, required 1 0 0 1",
               pattern_err, digit_valid[2], value[11:8], upd_cnt);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_err = 1'b0;
    checks++;
    if (pattern_err !== m_err) begin
      errors++;
      $display("FAIL clr_err: err %b, required 0", pattern_err);
    end
  endtask

  task automatic test_multi_enable();
    upd_cnt = 0;
    hold(1'b1, 1'b0, 1'b0, 7'h30, 1'b0, 6);
    drain();
    checks++;
    if (pattern_err !== 1'b1 || upd_cnt !== 0 || value !== m_value) begin
      errors++;
      $display("FAIL multi_en: err %b updates %0d value %h, required 1 0 %h",
               pattern_err, upd_cnt, value, m_value);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic test_blank();
    upd_cnt = 0;
    hold(1'b0, 1'b1, 1'b1, 7'h00, 1'b0, S);
    drain();
    checks++;
    if (upd_cnt !== 1 || digit_valid[0] !== 1'b0 || pattern_err !== 1'b0 || value[3:0] !== 4'h2) begin
      errors++;
      $display("FAIL blank: updates %0d valid0 %b err %b nib %h, required 1 0 0 2",
               upd_cnt, digit_valid[0], pattern_err, value[3:0]);
    end
  endtask

  task automatic test_back_to_back();
    upd_cnt = 0;
    for (int h = 0; h < 16; h++) begin
      hold((h % 3) != 0, (h % 3) != 1, (h % 3) != 2, glyph[h], h[0], S);
    end
    drain();
    checks++;
    if (upd_cnt !== 16 || {value, digit_valid, dot_seen} !== {m_value, m_valid, m_dot}) begin
      errors++;
      $display("FAIL back_to_back: updates %0d state %h, required 16 %h",
               upd_cnt, {value, digit_valid, dot_seen}, {m_value, m_valid, m_dot});
    end
  endtask

  task automatic test_reset_mid();
    upd_cnt = 0;
    drive(1'b1, 1'b0, 1'b1, 7'h5B, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({value, digit_valid, dot_seen, update, pattern_err} !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid: got %h,%b,%b,%b,%b required all zero",
               value, digit_valid, dot_seen, update, pattern_err);
    end
    rst = 1'b0;
    m_value = 12'h000; m_valid = 3'b000; m_dot = 3'b000; m_err = 1'b0;
    model_decode(1, 7'h5B, 1'b1);
    repeat (S) @(negedge clk);
    checks++;
    if (upd_cnt !== 0 || update !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_early: updates %0d update %b, required 0 0", upd_cnt, update);
    end
    @(negedge clk);
    checks++;
    if (update !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_late: update %b, required 1", update);
    end
    last_key = {1'b1, 1'b0, 1'b1, ~7'h5B, 1'b0};
    run = S + 1;
    drain();
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (update === 1'b1) begin
          logic [17:0] exp_s;
          upd_cnt++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL update_unexpected: state %h, required no update", {value, digit_valid, dot_seen});
          end else begin
            exp_s = sb.pop_front();
            if ({value, digit_valid, dot_seen} !== exp_s) begin
              errors++;
              $display("FAIL decode: got %h required %h (value,valid,dot)", {value, digit_valid, dot_seen}, exp_s);
            end
          end
        end
      end
    join_none
    test_reset();
    test_digit2_zero();
    test_long_hold_dot();
    test_glitch();
    test_illegal_glyph();
    test_multi_enable();
    test_blank();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
